uart_bip_ctrl: RTL and testbench

Command sequencer between the UART and the BIP processor. It waits for a run command byte from the UART receiver, clears and runs the BIP until it halts, counts the executed cycles, and then transmits a fixed 7-byte report frame through the UART transmitter. It is the only master of the UART tx handshake and of the BIP run/clear controls in the top level.

---
 rtl/uart_bip_ctrl.sv | 155 +++++++++++++++
 tb/tb_uart_bip_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bip_ctrl.sv
// uart_bip_ctrl: command sequencer between the UART and the BIP processor.
// It waits for a run command byte and then clears and runs the BIP until it halts.
// It then transmits a 7-byte report frame:
//   status, acc[15:8], acc[7:0], pc[10:8], pc[7:0], cycles[15:8], cycles[7:0].
// Optional feature macro: UART_BIP_CTRL_TIMEOUT_EN. When it is defined, a run is aborted after
// TIMEOUT_CYCLES and the frame carries status 8'hEE.
module uart_bip_ctrl #(
    parameter logic [7:0]  CMD_RUN        = 8'h53,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        bip_clr,
    output logic        bip_enable,
    input  logic        bip_halt,
    input  logic [15:0] bip_acc,
    input  logic [10:0] bip_pc,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StLatch,
        StSend,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [7:0]      status_q, status_d;
    logic [6:0][7:0] frame_q, frame_d;
    logic [2:0]      idx_q, idx_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            bip_clr_q, bip_clr_d;
    logic            bip_enable_q, bip_enable_d;
    logic            busy_q, busy_d;

`ifndef UART_BIP_CTRL_TIMEOUT_EN
    // The run limit only matters when the abort path is compiled in.
    logic [15:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    // Sequencer next state: command decode, run counting, frame capture and byte stepping.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        unique case (state_q)
            StIdle: begin
                if (rx_done && (rx_data == CMD_RUN)) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                cnt_d    = '0;
                status_d = 8'h00;
                state_d  = StRun;
            end
            StRun: begin
                // A halt takes priority over an abort on the same cycle.
                if (bip_halt) begin
                    state_d = StLatch;
                end
`ifdef UART_BIP_CTRL_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_CYCLES) begin
                    status_d = 8'hEE;
                    state_d  = StLatch;
                end
`endif
                else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StLatch: begin
                frame_d = {cnt_q[7:0], cnt_q[15:8], bip_pc[7:0], {5'b0, bip_pc[10:8]},
                           bip_acc[7:0], bip_acc[15:8], status_q};
                idx_d   = 3'd0;
                state_d = StSend;
            end
            StSend: begin
                state_d = StWait;
            end
            StWait: begin
                if (tx_done) begin
                    if (idx_q == 3'd6) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StSend;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so that every output is a flop.
    always_comb begin
        tx_start_d   = (state_d == StSend);
        tx_data_d    = tx_data_q;
        if (state_d == StSend) begin
            tx_data_d = frame_d[idx_d];
        end
        bip_clr_d    = (state_d == StClear);
        bip_enable_d = (state_d == StRun);
        busy_d       = (state_d != StIdle);
    end

    // State and output registers; reset abandons any run or frame immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            status_q     <= 8'h00;
            frame_q      <= '0;
            idx_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            bip_clr_q    <= 1'b0;
            bip_enable_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            status_q     <= status_d;
            frame_q      <= frame_d;
            idx_q        <= idx_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            bip_clr_q    <= bip_clr_d;
            bip_enable_q <= bip_enable_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign bip_clr    = bip_clr_q;
    assign bip_enable = bip_enable_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_bip_ctrl.sv
// Self-checking bench for uart_bip_ctrl. Expected frames come from a reference model:
// the frame byte list is computed arithmetically from the run length and the BIP values.
module tb_uart_bip_ctrl;

    localparam logic [15:0] TO = 16'd100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        bip_clr;
    logic        bip_enable;
    logic        bip_halt = 1'b0;
    logic [15:0] bip_acc = 16'h0;
    logic [10:0] bip_pc = 11'h0;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int n_start = 0;
    int n_clr = 0;
    int n_en = 0;

    uart_bip_ctrl #(
        .CMD_RUN        (8'h53),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .bip_clr    (bip_clr),
        .bip_enable (bip_enable),
        .bip_halt   (bip_halt),
        .bip_acc    (bip_acc),
        .bip_pc     (bip_pc),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (tx_start)   n_start = n_start + 1;
        if (bip_clr)    n_clr = n_clr + 1;
        if (bip_enable) n_en = n_en + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " tx_start"}, 32'(tx_start), 32'd0);
        check({tag, " bip_clr"}, 32'(bip_clr), 32'd0);
        check({tag, " bip_enable"}, 32'(bip_enable), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // One command/run/report transaction. The BIP halts after `l` counted run cycles.
    // The transmitter answers `dly` cycles after each tx_start. Only `nbytes` bytes are
    // acknowledged; on return with nbytes < 7 the bench sits in the SEND cycle of byte nbytes.
    task automatic do_run(input string tag, input int l, input logic [15:0] acc,
                          input logic [10:0] pc, input int dly, input int nbytes);
        logic [7:0]  st;
        logic [15:0] cyc;
        logic [7:0]  fr[7];
        int          leff;
        int          clr0;
        int          st0;
        int          en0;
        st   = 8'h00;
        cyc  = (l > 65535) ? 16'hFFFF : 16'(l);
        leff = l;
`ifdef UART_BIP_CTRL_TIMEOUT_EN
        if (l > int'(TO)) begin
            st   = 8'hEE;
            cyc  = TO;
            leff = int'(TO);
        end
`endif
        fr[0] = st;
        fr[1] = 8'(acc / 256);
        fr[2] = 8'(acc % 256);
        fr[3] = 8'(pc / 256);
        fr[4] = 8'(pc % 256);
        fr[5] = 8'(cyc / 256);
        fr[6] = 8'(cyc % 256);

        @(negedge clk);
        clr0 = n_clr;
        st0 = n_start;
        en0 = n_en;
        rx_data = 8'h53;
        rx_done = 1'b1;
        bip_halt = 1'b0;
        bip_acc = acc;
        bip_pc = pc;
        @(negedge clk);
        rx_done = 1'b0;
        check({tag, " clr pulse"}, 32'(bip_clr), 32'd1);
        check({tag, " busy rise"}, 32'(busy), 32'd1);
        check({tag, " enable during clr"}, 32'(bip_enable), 32'd0);
        @(negedge clk);
        check({tag, " enable on"}, 32'(bip_enable), 32'd1);
        check({tag, " clr single"}, 32'(bip_clr), 32'd0);
        if (l == 0) bip_halt = 1'b1;
        for (int i = 1; i <= leff; i++) begin
            @(negedge clk);
            // Spurious command bytes and tx_done pulses while running must be ignored.
            rx_data = 8'h53;
            rx_done = ($urandom_range(0, 3) == 0);
            tx_done = ($urandom_range(0, 3) == 0);
            if (i == leff && leff == l) bip_halt = 1'b1;
        end
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        check({tag, " enable off"}, 32'(bip_enable), 32'd0);
        check({tag, " enable cycles"}, 32'(n_en - en0), 32'(leff + 1));

        for (int k = 0; k < nbytes; k++) begin
            @(negedge clk);
            tx_done = 1'b0;
            check({tag, $sformatf(" tx_start b%0d", k)}, 32'(tx_start), 32'd1);
            check({tag, $sformatf(" tx_data b%0d", k)}, 32'(tx_data), 32'(fr[k]));
            if (k == 0) begin
                // Frame must be frozen from here on.
                bip_halt = 1'b0;
                bip_acc = 16'($urandom);
                bip_pc = 11'($urandom);
            end
            for (int j = 1; j <= dly; j++) begin
                @(negedge clk);
                if (j == 1) begin
                    check({tag, $sformatf(" start drop b%0d", k)}, 32'(tx_start), 32'd0);
                    check({tag, $sformatf(" data hold b%0d", k)}, 32'(tx_data), 32'(fr[k]));
                end
                rx_data = 8'h53;
                rx_done = ($urandom_range(0, 2) == 0);
            end
            rx_done = 1'b0;
            tx_done = 1'b1;
        end
        @(negedge clk);
        tx_done = 1'b0;
        if (nbytes == 7) begin
            check({tag, " busy fall"}, 32'(busy), 32'd0);
            check({tag, " no start after frame"}, 32'(tx_start), 32'd0);
            check({tag, " start count"}, 32'(n_start - st0), 32'd7);
            check({tag, " clr count"}, 32'(n_clr - clr0), 32'd1);
            // Stray handshakes while idle must not wake the sequencer.
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            repeat (5) @(negedge clk);
            check({tag, " idle start count"}, 32'(n_start - st0), 32'd7);
            check({tag, " idle clr count"}, 32'(n_clr - clr0), 32'd1);
            check({tag, " idle busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int st_before;
        int clr_before;

        // Reset and idle.
        repeat (2) @(negedge clk);
        check("in reset tx_data", 32'(tx_data), 32'h00);
        check_idle_outputs("in reset");
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check_idle_outputs("idle");
        check("idle tx_data", 32'(tx_data), 32'h00);

        // Non-command byte is ignored.
        clr_before = n_clr;
        rx_data = 8'h41;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("ignore 41 clr", 32'(n_clr - clr_before), 32'd0);
        check("ignore 41 busy", 32'(busy), 32'd0);

        // Directed frame: bytes 00,12,34,02,A5,00,25.
        do_run("basic", 37, 16'h1234, 11'h2A5, 20, 7);
        // Halt on the very first RUN cycle.
        do_run("halt0", 0, 16'hBEEF, 11'h7FF, 1, 7);
        // Long run: counts 150 without timeout, aborts at 100 with it.
        do_run("long", 150, 16'h00FF, 11'h100, 3, 7);
`ifdef UART_BIP_CTRL_TIMEOUT_EN
        // Halt coinciding with the limit: halt wins.
        do_run("coincide", int'(TO), 16'h5A5A, 11'h0F0, 2, 7);
`endif
        // Randomized runs.
        for (int r = 0; r < 3; r++) begin
            do_run($sformatf("rand%0d", r), int'($urandom_range(0, 60)), 16'($urandom),
                   11'($urandom), int'($urandom_range(1, 25)), 7);
        end

        // Reset during the third WAIT abandons the frame.
        do_run("abort", 12, 16'hCAFE, 11'h321, 4, 2);
        check("abort third start", 32'(tx_start), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async reset tx_data", 32'(tx_data), 32'h00);
        check_idle_outputs("async reset");
        @(negedge clk);
        reset = 1'b1;
        st_before = n_start;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (20) @(negedge clk);
        check("post reset no start", 32'(n_start - st_before), 32'd0);
        check("post reset busy", 32'(busy), 32'd0);
        do_run("fresh", 5, 16'h0102, 11'h003, 2, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
